// File: rtl/reg_pipe.sv
// Elastic DEPTH-stage register pipeline; bubbles collapse forward, latency DEPTH cycles, o_ready is a
// combinational ready chain from i_ready. Define REG_PIPE_COUNT_EN to add the registered o_count port.
module reg_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
`ifdef REG_PIPE_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] o_count
`endif
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] drain;
  logic             advance;

  assign advance = i_enable & ~i_flush;

  // Ready chain, evaluated from the output side back towards the input.
  always_comb begin
    load           = '0;
    drain          = '0;
    drain[DEPTH-1] = vld_q[DEPTH-1] & i_ready;
    load[DEPTH-1]  = advance & (~vld_q[DEPTH-1] | drain[DEPTH-1]);
    for (int k = DEPTH - 2; k >= 0; k--) begin
      drain[k] = load[k+1];
      load[k]  = advance & (~vld_q[k] | drain[k]);
    end
  end

  // Flush clears only the valid bits; stage data is left untouched.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (load[0]) begin
      vld_d[0] = i_valid;
      dat_d[0] = i_data;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (load[k]) begin
        vld_d[k] = vld_q[k-1];
        dat_d[k] = dat_q[k-1];
      end
    end
    if (i_flush) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign o_ready = load[0];
  assign o_valid = vld_q[DEPTH-1];
  assign o_data  = dat_q[DEPTH-1];

`ifdef REG_PIPE_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_d = cnt_d + CW'(vld_d[k]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_count = cnt_q;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Scoreboard bench for reg_pipe: instance 0 has DEPTH=2, instance 1 has DEPTH=4.
module tb_reg_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst;
  logic [1:0]      en;
  logic [1:0]      flush;
  logic [1:0]      vin;
  logic [1:0]      rdy;
  logic [1:0][7:0] din;
  wire  [1:0]      o_rdy;
  wire  [1:0]      ov;
  wire  [1:0][7:0] dout;
`ifdef REG_PIPE_COUNT_EN
  wire  [1:0]      cnt0;
  wire  [2:0]      cnt1;
`endif

  reg_pipe #(.WIDTH(8), .DEPTH(2)) u_p2 (
    .i_clk   (clk),
    .i_rst   (rst[0]),
    .i_enable(en[0]),
    .i_flush (flush[0]),
    .i_valid (vin[0]),
    .i_data  (din[0]),
    .o_ready (o_rdy[0]),
    .o_valid (ov[0]),
    .o_data  (dout[0]),
    .i_ready (rdy[0])
`ifdef REG_PIPE_COUNT_EN
    ,
    .o_count (cnt0)
`endif
  );

  reg_pipe #(.WIDTH(8), .DEPTH(4)) u_p4 (
    .i_clk   (clk),
    .i_rst   (rst[1]),
    .i_enable(en[1]),
    .i_flush (flush[1]),
    .i_valid (vin[1]),
    .i_data  (din[1]),
    .o_ready (o_rdy[1]),
    .o_valid (ov[1]),
    .o_data  (dout[1]),
    .i_ready (rdy[1])
`ifdef REG_PIPE_COUNT_EN
    ,
    .o_count (cnt1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_out [2];
  int first_out [2];
  int last_out [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] qfront(input int s);
    if (s == 0) return (q0.size() > 0) ? q0[0] : 8'h00;
    return (q1.size() > 0) ? q1[0] : 8'h00;
  endfunction

  function automatic logic [7:0] qpop(input int s);
    if (s == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic qpush(input int s, input logic [7:0] d);
    if (s == 0) q0.push_back(d);
    else q1.push_back(d);
  endtask

  task automatic qclear(input int s);
    if (s == 0) q0.delete();
    else q1.delete();
  endtask

  // Observe one instance at the falling edge: outputs first, then the beat entering.
  task automatic monitor(input int s);
    logic [7:0] e;
    if (rst[s]) begin
      qclear(s);
      return;
    end
`ifdef REG_PIPE_COUNT_EN
    check($sformatf("u%0d.count", s), (s == 0) ? 32'(cnt0) : 32'(cnt1), 32'(qsize(s)));
`endif
    if (en[s] && !flush[s] && ov[s] && rdy[s]) begin
      check($sformatf("u%0d.out_expected", s), 32'(qsize(s) > 0), 32'd1);
      if (qsize(s) > 0) begin
        e = qpop(s);
        check($sformatf("u%0d.data", s), 32'(dout[s]), 32'(e));
      end
      if (n_out[s] == 0) first_out[s] = cyc;
      last_out[s] = cyc;
      n_out[s]++;
    end
    if (flush[s]) qclear(s);
    else if (en[s] && vin[s] && o_rdy[s]) qpush(s, din[s]);
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) monitor(s);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int s, input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while ((qsize(s) != 0 || ov[s]) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("u%0d.drained", s), 32'(qsize(s) == 0 && !ov[s]), 32'd1);
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int k;
    rst = 2'b11; en = 2'b11; flush = 2'b00; vin = 2'b11; rdy = 2'b00;
    din[0] = 8'hFF; din[1] = 8'hFF;
    n_out[0] = 0; n_out[1] = 0;

    // Reset with a beat offered; nothing must survive
    tick(2);
    rst = 2'b00; vin = 2'b00;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("u%0d.rst_valid", s), 32'(ov[s]), 32'd0);
      check($sformatf("u%0d.rst_data", s), 32'(dout[s]), 32'd0);
      check($sformatf("u%0d.rst_ready", s), 32'(o_rdy[s]), 32'd1);
    end
    tick(1);

    // Streaming on DEPTH=2
    rdy[0] = 1'b1; n_out[0] = 0; acc = 0;
    for (int i = 1; i <= 16; i++) begin
      vin[0] = 1'b1; din[0] = 8'(i);
      if (i == 1) acc = cyc;
      @(negedge clk);
      check("u0.stream_ready", 32'(o_rdy[0]), 32'd1);
      tick(1);
    end
    vin[0] = 1'b0;
    wait_drain(0, 40);
    check("u0.latency", 32'(first_out[0] - acc), 32'd2);
    check("u0.no_gaps", 32'(last_out[0] - first_out[0]), 32'd15);
    check("u0.beats", 32'(n_out[0]), 32'd16);

    // Backpressure on DEPTH=2
    rdy[0] = 1'b0;
    vin[0] = 1'b1; din[0] = 8'hA1; tick(1);
    din[0] = 8'hA2; tick(1);
    vin[0] = 1'b0;
    @(negedge clk);
    check("u0.bp_ready", 32'(o_rdy[0]), 32'd0);
    check("u0.bp_valid", 32'(ov[0]), 32'd1);
    check("u0.bp_data", 32'(dout[0]), 32'hA1);
    check("u0.bp_beats", 32'(qsize(0)), 32'd2);
    tick(3);
    @(negedge clk);
    check("u0.bp_hold", 32'(dout[0]), 32'hA1);
    tick(1);
    rdy[0] = 1'b1; n_out[0] = 0;
    wait_drain(0, 20);
    check("u0.bp_drain_n", 32'(n_out[0]), 32'd2);
    check("u0.bp_drain_back2back", 32'(last_out[0] - first_out[0]), 32'd1);

    // Bubble collapse on DEPTH=4
    rdy[1] = 1'b0;
    vin[1] = 1'b1; din[1] = 8'h55; tick(1);
    vin[1] = 1'b0; tick(4);
    @(negedge clk);
    check("u1.bub_valid", 32'(ov[1]), 32'd1);
    check("u1.bub_data", 32'(dout[1]), 32'h55);
    check("u1.bub_ready", 32'(o_rdy[1]), 32'd1);
    tick(1);
    k = 0;
    while (k < 8) begin
      vin[1] = 1'b1; din[1] = 8'(8'h60 + k);
      @(negedge clk);
      if (!o_rdy[1]) break;
      tick(1);
      k++;
    end
    check("u1.fill_beats", 32'(k), 32'd3);
    check("u1.full_beats", 32'(qsize(1)), 32'd4);
    check("u1.full_data", 32'(dout[1]), 32'h55);
    tick(1);
    vin[1] = 1'b0; rdy[1] = 1'b1;
    wait_drain(1, 30);

    // Enable hold mid-stream on DEPTH=4
    n_out[1] = 0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      vin[1] = 1'b1; din[1] = 8'(8'hC0 + i);
      if (i == 0) acc = cyc;
      tick(1);
    end
    en[1] = 1'b0; din[1] = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("u1.hold_ready", 32'(o_rdy[1]), 32'd0);
      check("u1.hold_valid", 32'(ov[1]), 32'd1);
      check("u1.hold_data", 32'(dout[1]), 32'(qfront(1)));
      tick(1);
    end
    en[1] = 1'b1;
    for (int i = 6; i < 10; i++) begin
      din[1] = 8'(8'hC0 + i);
      tick(1);
    end
    vin[1] = 1'b0;
    wait_drain(1, 40);
    check("u1.latency", 32'(first_out[1] - acc), 32'd4);
    check("u1.hold_beats", 32'(n_out[1]), 32'd10);

    // Flush with three beats held on DEPTH=4
    rdy[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vin[1] = 1'b1; din[1] = 8'(8'h81 + i);
      tick(1);
    end
    flush[1] = 1'b1; din[1] = 8'h77;
    @(negedge clk);
    check("u1.flush_ready", 32'(o_rdy[1]), 32'd0);
    tick(1);
    flush[1] = 1'b0; vin[1] = 1'b0;
    @(negedge clk);
    check("u1.flush_valid", 32'(ov[1]), 32'd0);
    tick(1);
    rdy[1] = 1'b1; n_out[1] = 0;
    tick(8);
    check("u1.flush_no_out", 32'(n_out[1]), 32'd0);
    vin[1] = 1'b1; din[1] = 8'h91; tick(1);
    din[1] = 8'h92; tick(1);
    vin[1] = 1'b0;
    wait_drain(1, 30);
    check("u1.post_flush_beats", 32'(n_out[1]), 32'd2);

    // Flush while disabled on DEPTH=2
    rdy[0] = 1'b0;
    vin[0] = 1'b1; din[0] = 8'h31; tick(1);
    din[0] = 8'h32; tick(1);
    vin[0] = 1'b0; en[0] = 1'b0; flush[0] = 1'b1;
    tick(1);
    en[0] = 1'b1; flush[0] = 1'b0;
    @(negedge clk);
    check("u0.dis_flush_valid", 32'(ov[0]), 32'd0);
    tick(1);
    rdy[0] = 1'b1; n_out[0] = 0;
    tick(4);
    check("u0.dis_flush_no_out", 32'(n_out[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_pipe.md
# reg_pipe

Parametrised elastic register pipeline: `DEPTH` stages of `WIDTH`-bit data, each with a valid bit and a valid/ready handshake on both sides. Empty stages ("bubbles") collapse forward, so an upstream stall does not waste capacity. A global enable holds the whole pipeline, and a flush clears it. Used wherever a datapath needs registered retiming with backpressure between producer and consumer blocks.

## Interface
Parameters:
- `WIDTH`, 8, data width in bits (≥1)
- `DEPTH`, 2, number of register stages (≥1)

Ports:
- `i_clk`  in  1  clock; all state changes on its rising edge
- `i_rst`  in  1  reset, synchronous, active-high
- `i_enable`  in  1  global advance enable; low holds all stages
- `i_flush`  in  1  synchronous clear of all valid bits
- `i_valid`  in  1  upstream data valid
- `i_data`  in  WIDTH  upstream data
- `o_ready`  out  1  pipeline can accept `i_data` this cycle
- `o_valid`  out  1  last stage holds valid data
- `o_data`  out  WIDTH  last-stage data
- `i_ready`  in  1  downstream accepts `o_data` this cycle
- `o_count`  out  $clog2(DEPTH+1)  number of valid stages (present only with `REG_PIPE_COUNT_EN`)

## Operation
- State per stage k (0 = input side, DEPTH-1 = output side): `vld[k]`, `dat[k]`.
- Reset: all `vld` = 0 and all `dat` = 0. Consequently `o_valid` = 0, `o_data` = 0, `o_count` = 0, and `o_ready` = `i_enable`.
- Stage k can load when `i_enable` is high and either stage k is empty or stage k drains this cycle.
  - Stage DEPTH-1 drains when `vld[DEPTH-1] & i_ready`.
  - Stage k<DEPTH-1 drains when stage k+1 loads from it.
- `o_ready` = load condition of stage 0. Transfer in occurs when `i_valid & o_ready`.
- On load, stage k takes `dat[k-1]`/`vld[k-1]` (stage 0 takes `i_data`/`i_valid`).
- A stage that neither loads nor drains holds its value. Data is never dropped or duplicated, and order is preserved.
- `dat` of an invalid stage is don't-care for function. It must not be cleared except by reset.
- `i_enable` low: no stage changes, `o_ready` = 0. `o_valid` still reflects `vld[DEPTH-1]`, but no output transfer is counted. The downstream must treat the `o_valid & i_ready` handshake as void while `i_enable` = 0.
- `i_flush` high (with `i_enable` either value): next cycle all `vld` = 0. The input beat offered in the flush cycle is discarded, and `o_ready` = 0 during flush.
- Priority: `i_rst` > `i_flush` > `i_enable` > handshake.

## Timing
- Latency: a beat accepted at edge N appears on `o_valid`/`o_data` after edge N+DEPTH-1 (i.e. DEPTH registers) when unstalled.
- Throughput: 1 beat/cycle sustained with `i_ready` = 1.
- `o_valid`, `o_data`, `o_count` are registered outputs.
- `o_ready` is combinational from `i_ready`, `i_enable`, `i_flush` and the `vld` bits. This is a ready chain through all stages; `DEPTH` bounds its length.
- Full (all `vld` = 1) with `i_ready` = 0: `o_ready` = 0. With `i_ready` = 1 the pipeline is full but still accepts, shifting every stage in the same cycle.
- Reset asserted mid-stream: the next edge clears all state, and in-flight beats are lost.

## Configuration
- `REG_PIPE_COUNT_EN` defined: `o_count` port exists, equal to popcount of `vld`. It is registered, updated on the same edge as `vld`, and has range 0..DEPTH.
- Not defined: the port and its logic are absent. The rest of the behaviour is identical.

## Test plan
- Reset: assert `i_rst` 2 cycles with `i_valid`=1, `i_data`=8'hFF -> `o_valid`=0, `o_data`=8'h00, `o_count`=0 after release.
- Streaming, DEPTH=2: drive 8'h01..8'h10 back-to-back with `i_ready`=1 -> 8'h01 on output 2 cycles after its accept, then one beat per cycle in order, with no gaps.
- Backpressure: fill with 8'hA1, 8'hA2 while `i_ready`=0 -> `o_ready`=0, `o_count`=2, `o_data`=8'hA1 held. Raise `i_ready` -> A1 then A2 drain in consecutive cycles.
- Bubble collapse, DEPTH=4: single beat 8'h55, then `i_ready`=0 -> it advances to stage 3. Further beats fill stages 2..0 until `o_ready`=0 with `o_count`=4.
- Enable hold: `i_enable`=0 for 3 cycles mid-stream -> no state change, `o_ready`=0. The stream resumes intact once `i_enable` returns to 1.
- Flush: pipeline holding 3 beats, pulse `i_flush` one cycle with `i_valid`=1, `i_data`=8'h77 -> `o_valid`=0, `o_count`=0 next cycle, and 8'h77 never appears on the output.
